drm_metering_arbiter: RTL and testbench

- Shares the single metering-event input of the DRM Activator between NUM_REQ user IP cores.
- Each requester pulses one-cycle usage events. The block buffers them in per-requester saturating pending counters.
- Buffered events are forwarded one at a time to the Activator over a valid/ready port, tagged with the requester ID and selected by round-robin.
- Forwarding is gated by Activator activation status. The block sits in the IP-core clock domain, between the user cores and the Activator metering port.

---
 rtl/drm_metering_arbiter_pkg.sv | 38 +++
 rtl/drm_metering_arbiter_rr_pick.sv | 29 ++
 rtl/drm_metering_arbiter.sv | 112 +++++++++++
 tb/tb_drm_metering_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/drm_metering_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the DRM metering arbiter
// and other Activator-side arbiters.
package drm_metering_arbiter_pkg;

    localparam int MAX_NUM_REQ = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Scanning downward lets the lowest offset from the pointer win.
    function automatic pick_t rr_pick(
        input logic [MAX_NUM_REQ-1:0] req_mask,
        input logic [3:0]             pointer,
        input int                     num_req
    );
        pick_t r;
        int    idx;
        r = '0;
        for (int k = MAX_NUM_REQ - 1; k >= 0; k--) begin
            if (k < num_req) begin
                idx = (int'(pointer) + k) % num_req;
                if (req_mask[4'(idx)]) begin
                    r.found = 1'b1;
                    r.idx   = 4'(idx);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/drm_metering_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or above the
// pointer, wrapping at NUM_REQ.
module drm_rr_pick
    import drm_metering_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic [ID_W-1:0]    pointer,
    output logic [ID_W-1:0]    grant,
    output logic               found
);

    logic [MAX_NUM_REQ-1:0] mask_ext;
    logic [3:0]             ptr_ext;
    pick_t                  pick;

    always_comb begin
        mask_ext                = '0;
        mask_ext[NUM_REQ-1:0]   = req_mask;
        ptr_ext                 = '0;
        ptr_ext[ID_W-1:0]       = pointer;
        pick                    = rr_pick(mask_ext, ptr_ext, NUM_REQ);
        grant                   = ID_W'(pick.idx);
        found                   = pick.found;
    end

endmodule

// File: rtl/drm_metering_arbiter.sv
// Buffers per-requester metering events in saturating counters and forwards
// them one at a time, round-robin, to the Activator metering port.
module drm_metering_arbiter
    import drm_metering_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               ip_core_aclk,
    input  logic               ip_core_rst,
    input  logic               activation_code_ready,
    input  logic [NUM_REQ-1:0] activation_code_bit,
    input  logic [NUM_REQ-1:0] req_event,
    output logic               evt_valid,
    output logic [ID_W-1:0]    evt_id,
    input  logic               evt_ready,
    output logic               pending_any,
    output logic [NUM_REQ-1:0] overflow,
    input  logic               overflow_clr
);

    // Handshake: an event transfers on any cycle with evt_valid & evt_ready;
    // once raised, evt_valid and evt_id hold until that transfer.

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]   count_q [NUM_REQ];
    logic [NUM_REQ-1:0] nonzero;
    logic [NUM_REQ-1:0] inc;
    logic [NUM_REQ-1:0] dec;
    logic [NUM_REQ-1:0] ovf_set;
    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    evt_id_d;
    logic [ID_W-1:0]    grant;
    logic               found;
    logic               handshake;

    assign evt_valid   = (state_q == OFFER);
    assign handshake   = evt_valid & evt_ready;
    assign pending_any = |nonzero;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            nonzero[i] = |count_q[i];
            inc[i]     = req_event[i] & activation_code_bit[i];
            dec[i]     = handshake && (evt_id == ID_W'(i));
            ovf_set[i] = inc[i] && !dec[i] && (count_q[i] == CNT_MAX);
        end
    end

    drm_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_mask (nonzero),
        .pointer  (ptr_q),
        .grant    (grant),
        .found    (found)
    );

    always_ff @(posedge ip_core_aclk) begin
        if (ip_core_rst) begin
            for (int i = 0; i < NUM_REQ; i++) count_q[i] <= '0;
            overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (inc[i] && !dec[i] && !ovf_set[i])
                    count_q[i] <= count_q[i] + CNT_W'(1);
                else if (dec[i] && !inc[i])
                    count_q[i] <= count_q[i] - CNT_W'(1);
            end
            // A drop in the same cycle as a clear keeps its flag.
            overflow <= (overflow_clr ? '0 : overflow) | ovf_set;
        end
    end

    always_comb begin
        state_d  = state_q;
        evt_id_d = evt_id;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                if (activation_code_ready && found) begin
                    state_d  = OFFER;
                    evt_id_d = grant;
                end
            end
            OFFER: begin
                if (handshake) begin
                    state_d = IDLE;
                    ptr_d   = (evt_id == ID_W'(NUM_REQ - 1)) ? '0 : evt_id + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ip_core_aclk) begin
        if (ip_core_rst) begin
            state_q <= IDLE;
            evt_id  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            evt_id  <= evt_id_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_drm_metering_arbiter.sv
// Bench for drm_metering_arbiter: directed scenarios plus random traffic,
// checked every cycle against an event-level reference model.
module tb_drm_metering_arbiter;

    localparam int N    = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int IW   = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          act_ready;
    logic [N-1:0]  act_bit;
    logic [N-1:0]  req_event;
    logic          evt_valid;
    logic [IW-1:0] evt_id;
    logic          evt_ready;
    logic          pending_any;
    logic [N-1:0]  overflow;
    logic          overflow_clr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int       m_cnt [N];
    bit [N-1:0] m_ov;
    bit       m_valid;
    int       m_id;
    int       m_ptr;

    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] got_q[$];

    drm_metering_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
        .ip_core_aclk          (clk),
        .ip_core_rst           (rst),
        .activation_code_ready (act_ready),
        .activation_code_bit   (act_bit),
        .req_event             (req_event),
        .evt_valid             (evt_valid),
        .evt_id                (evt_id),
        .evt_ready             (evt_ready),
        .pending_any           (pending_any),
        .overflow              (overflow),
        .overflow_clr          (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            if (m_cnt[(m_ptr + k) % N] > 0) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit model_pending();
        for (int i = 0; i < N; i++) if (m_cnt[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: predict from the current inputs, advance, then compare.
    task automatic tick();
        int         n_cnt [N];
        bit [N-1:0] n_ov;
        bit         n_valid;
        int         n_id, n_ptr, g;
        bit         hs, inc, dec;
        if (rst) begin
            for (int i = 0; i < N; i++) n_cnt[i] = 0;
            n_ov = '0; n_valid = 0; n_id = 0; n_ptr = 0;
        end else begin
            hs   = m_valid && evt_ready;
            n_ov = overflow_clr ? '0 : m_ov;
            for (int i = 0; i < N; i++) begin
                n_cnt[i] = m_cnt[i];
                inc = req_event[i] && act_bit[i];
                dec = hs && (m_id == i);
                if (inc && !dec) begin
                    if (m_cnt[i] == CMAX) n_ov[i] = 1'b1;
                    else n_cnt[i] = m_cnt[i] + 1;
                end else if (dec && !inc) begin
                    n_cnt[i] = m_cnt[i] - 1;
                end
            end
            n_valid = m_valid; n_id = m_id; n_ptr = m_ptr;
            if (m_valid) begin
                if (hs) begin
                    n_valid = 0;
                    n_ptr   = (m_id + 1) % N;
                end
            end else if (act_ready) begin
                g = model_pick();
                if (g >= 0) begin
                    n_valid = 1;
                    n_id    = g;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) m_cnt[i] = n_cnt[i];
        m_ov = n_ov; m_valid = n_valid; m_id = n_id; m_ptr = n_ptr;
        check_eq("evt_valid", evt_valid, m_valid);
        check_eq("evt_id", evt_id, m_id);
        check_eq("pending_any", pending_any, model_pending());
        check_eq("overflow", overflow, m_ov);
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        req_event = mask;
        tick();
        req_event = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; act_ready = 1'b0; act_bit = '1; req_event = '0;
        evt_ready = 1'b0; overflow_clr = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ov = '0; m_valid = 0; m_id = 0; m_ptr = 0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_valid", evt_valid, 0);
        check_eq("rst_pending", pending_any, 0);
        check_eq("rst_overflow", overflow, 0);

        // Single event: offer two cycles after the pulse, then drained.
        act_ready = 1'b1; evt_ready = 1'b1;
        pulse(4'b0100);
        check_eq("t1_not_yet", evt_valid, 0);
        tick();
        check_eq("t1_valid", evt_valid, 1);
        check_eq("t1_id", evt_id, 2);
        tick();
        check_eq("t1_drained", pending_any, 0);

        // Round-robin fairness over requesters 0, 1, 3.
        do_reset();
        act_ready = 1'b0; evt_ready = 1'b0;
        repeat (3) pulse(4'b1011);
        act_ready = 1'b1; evt_ready = 1'b1;
        exp_q.delete(); got_q.delete();
        repeat (3) begin
            exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        end
        repeat (20) begin
            tick();
            if (evt_valid) got_q.push_back(evt_id);
        end
        check_eq("t2_count", got_q.size(), 9);
        while (exp_q.size() > 0 && got_q.size() > 0)
            check_eq("t2_order", got_q.pop_front(), exp_q.pop_front());

        // Backpressure with activation dropped mid-offer.
        evt_ready = 1'b0;
        pulse(4'b0011);
        tick();
        check_eq("t3_valid", evt_valid, 1);
        check_eq("t3_id", evt_id, 0);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) act_ready = 1'b0;
            tick();
            check_eq("t3_hold_id", evt_id, 0);
        end
        evt_ready = 1'b1;
        repeat (5) tick();
        check_eq("t3_gated", evt_valid, 0);
        act_ready = 1'b1;
        tick();
        check_eq("t3_resume_id", evt_id, 1);
        repeat (4) tick();

        // Saturation and overflow clear priority.
        do_reset();
        act_ready = 1'b0;
        repeat (5) pulse(4'b0010);
        check_eq("t4_ovf_set", overflow, 4'b0010);
        overflow_clr = 1'b1;
        pulse(4'b0010);
        overflow_clr = 1'b0;
        check_eq("t4_set_wins", overflow, 4'b0010);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check_eq("t4_cleared", overflow, 0);
        act_ready = 1'b1; evt_ready = 1'b1;
        got_q.delete();
        repeat (8) begin
            tick();
            if (evt_valid) got_q.push_back(evt_id);
        end
        check_eq("t4_drain_count", got_q.size(), 3);

        // Increment in the handshake cycle keeps the count.
        do_reset();
        act_ready = 1'b1; evt_ready = 1'b0;
        pulse(4'b0001);
        tick();
        evt_ready = 1'b1;
        pulse(4'b0001);
        evt_ready = 1'b0;
        check_eq("t5_pending", pending_any, 1);
        tick();
        check_eq("t5_reoffer", evt_valid, 1);
        check_eq("t5_reoffer_id", evt_id, 0);
        evt_ready = 1'b1;
        repeat (3) tick();

        // Disabled requester, then reset during an offer.
        do_reset();
        act_bit = 4'b0111; act_ready = 1'b0;
        pulse(4'b1000);
        check_eq("t6_no_count", pending_any, 0);
        check_eq("t6_no_ovf", overflow, 0);
        act_bit = '1; act_ready = 1'b1; evt_ready = 1'b1;
        pulse(4'b0010);
        repeat (2) tick();
        evt_ready = 1'b0;
        pulse(4'b0100);
        tick();
        check_eq("t6_offer", evt_valid, 1);
        do_reset();
        check_eq("t6_rst_valid", evt_valid, 0);
        pulse(4'b1001);
        tick();
        check_eq("t6_ptr_zero", evt_id, 0);
        evt_ready = 1'b1;
        repeat (4) tick();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            act_ready    = ($urandom_range(0, 3) != 0);
            act_bit      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            req_event    = N'($urandom) & N'($urandom);
            evt_ready    = ($urandom_range(0, 2) != 0);
            overflow_clr = ($urandom_range(0, 19) == 0);
            tick();
        end
        rst = 1'b0; req_event = '0; overflow_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
